// File: rtl/pattern_lock_pkg.sv
// pattern_lock_pkg
//   Shared definitions for the pattern lock detector: FSM state encoding,
//   default parameter values and a helper that extracts one word from the
//   flat pattern vector (word 0 is the most-significant word).
package pattern_lock_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PAT_WORDS = 4;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_LOSS_THR  = 4;
  localparam int DEF_ERR_W     = 16;

  // Upper bounds for the generic word extractor; callers zero-extend the
  // pattern to MAX_FLAT_W and truncate the result to their own word width.
  localparam int MAX_FLAT_W = 1024;
  localparam int MAX_DATA_W = 64;

  function automatic logic [MAX_DATA_W-1:0] pattern_word(
    input logic [MAX_FLAT_W-1:0] flat,
    input int unsigned           data_w,
    input int unsigned           pat_words,
    input int unsigned           i
  );
    return MAX_DATA_W'(flat >> ((pat_words - 1 - i) * data_w));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear (clear wins over inc).
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset
//     inc   - increment request
//     clr   - synchronous clear
//     count - current count, holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pattern_lock_detector.sv
// pattern_lock_detector
//   Checks a word stream against a programmable PAT_WORDS-word pattern and
//   declares lock after n back-to-back repetitions (n = 0 behaves as 1).
//   While locked, counts mismatched words and drops lock after LOSS_THR
//   consecutive mismatches.
//   Ports:
//     clk, rst          - clock (rising edge), synchronous active-high reset
//     pattern           - flat pattern, word 0 in the MSBs, expected first
//     n                 - required consecutive repetitions
//     in_valid/prbs_out - stream word qualifier and data
//     err_clr           - synchronous clear of err_count
//     pattern_detected  - high while locked
//     locked_pulse      - one cycle on lock entry
//     loss_pulse        - one cycle on lock exit
//     err_count         - saturating mismatch count while locked
//   Build option: define PATTERN_LOCK_ERRCNT_EN to build the error counter;
//   otherwise err_count is tied to 0 and err_clr is ignored.
module pattern_lock_detector
  import pattern_lock_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PAT_WORDS = DEF_PAT_WORDS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LOSS_THR  = DEF_LOSS_THR,
  parameter int ERR_W     = DEF_ERR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W*PAT_WORDS-1:0]   pattern,
  input  logic [CNT_W-1:0]              n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             prbs_out,
  input  logic                          err_clr,
  output logic                          pattern_detected,
  output logic                          locked_pulse,
  output logic                          loss_pulse,
  output logic [ERR_W-1:0]              err_count
);

  localparam int IDX_W  = (PAT_WORDS > 1) ? $clog2(PAT_WORDS) : 1;
  localparam int MISS_W = $clog2(LOSS_THR + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PAT_WORDS - 1);
  localparam logic [MISS_W-1:0] MISS_THR = MISS_W'(LOSS_THR);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    rep_q;
  logic [MISS_W-1:0]   miss_q;
  logic                detected_q;
  logic                locked_pulse_q;
  logic                loss_pulse_q;

  logic [MAX_FLAT_W-1:0] pattern_ext;
  logic [DATA_W-1:0]     word_exp;
  logic [DATA_W-1:0]     word_first;
  logic                  match_cur;
  logic                  match_first;
  logic [CNT_W-1:0]      n_eff;
  logic [IDX_W-1:0]      idx_d;
  logic [CNT_W-1:0]      rep_d;
  logic [MISS_W-1:0]     miss_d;
  logic                  err_inc;

  assign pattern_ext = MAX_FLAT_W'(pattern);
  assign word_exp    = DATA_W'(pattern_word(pattern_ext, DATA_W, PAT_WORDS, 32'(idx_q)));
  assign word_first  = DATA_W'(pattern_word(pattern_ext, DATA_W, PAT_WORDS, 32'd0));
  assign match_cur   = (prbs_out == word_exp);
  assign match_first = (prbs_out == word_first);

  assign n_eff  = (n == '0) ? CNT_W'(1) : n;
  assign idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  assign rep_d  = rep_q + CNT_W'(1);
  assign miss_d = miss_q + MISS_W'(1);

  assign err_inc = in_valid && (state_q == LOCKED) && !match_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SEARCH;
      idx_q          <= '0;
      rep_q          <= '0;
      miss_q         <= '0;
      detected_q     <= 1'b0;
      locked_pulse_q <= 1'b0;
      loss_pulse_q   <= 1'b0;
    end else begin
      locked_pulse_q <= 1'b0;
      loss_pulse_q   <= 1'b0;
      if (in_valid) begin
        case (state_q)
          SEARCH: begin
            if (match_first) begin
              state_q <= TRACK;
              idx_q   <= IDX_W'(1);
              rep_q   <= '0;
            end
          end
          TRACK: begin
            if (match_cur) begin
              idx_q <= idx_d;
              if (idx_q == IDX_LAST) begin
                rep_q <= rep_d;
                if (rep_d == n_eff) begin
                  state_q        <= LOCKED;
                  miss_q         <= '0;
                  detected_q     <= 1'b1;
                  locked_pulse_q <= 1'b1;
                end
              end
            end else begin
              // A broken run may itself be the start of a new one.
              rep_q <= '0;
              if (match_first) begin
                idx_q <= IDX_W'(1);
              end else begin
                state_q <= SEARCH;
                idx_q   <= '0;
              end
            end
          end
          LOCKED: begin
            // Position free-runs; mismatches never resynchronise it.
            idx_q <= idx_d;
            if (match_cur) begin
              miss_q <= '0;
            end else if (miss_d == MISS_THR) begin
              state_q      <= SEARCH;
              idx_q        <= '0;
              rep_q        <= '0;
              miss_q       <= '0;
              detected_q   <= 1'b0;
              loss_pulse_q <= 1'b1;
            end else begin
              miss_q <= miss_d;
            end
          end
          default: begin
            state_q <= SEARCH;
            idx_q   <= '0;
            rep_q   <= '0;
            miss_q  <= '0;
          end
        endcase
      end
    end
  end

  assign pattern_detected = detected_q;
  assign locked_pulse     = locked_pulse_q;
  assign loss_pulse       = loss_pulse_q;

`ifdef PATTERN_LOCK_ERRCNT_EN
  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .clr  (err_clr),
    .count(err_count)
  );
`else
  logic unused_err;
  assign unused_err = err_clr ^ err_inc;
  assign err_count  = '0;
`endif

endmodule
